counter_ud: RTL and testbench

COUNTER_UD -- requirements
Module: counter_ud

---
 rtl/counter_pkg.sv | 29 ++
 rtl/counter_ud_if.sv | 34 +++
 rtl/counter_ud_core.sv | 52 +++++
 rtl/counter_ud.sv | 74 +++++++
 tb/tb_counter_ud.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/counter_pkg.sv
// Shared constants and Gray-code helpers for the up/down counter.
package counter_pkg;

  localparam int unsigned MAX_W    = 32;
  localparam int unsigned SAT_WRAP = 0;
  localparam int unsigned SAT_HOLD = 1;

  typedef enum logic [2:0] {
    OpHold,
    OpClr,
    OpLoad,
    OpUp,
    OpDown
  } op_e;

  function automatic logic [31:0] b2g(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] g2b(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/counter_ud_if.sv
// Control/status bundle of counter_ud. count_g exists only with COUNTER_UD_GRAY_EN.
interface counter_ud_if #(
  parameter int unsigned W = 12
);
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic         inc;
  logic         dec;
  logic [W-1:0] cmp_val;
  logic [W-1:0] count;
`ifdef COUNTER_UD_GRAY_EN
  logic [W-1:0] count_g;
`endif
  logic         match;
  logic         wrap;
  logic         err;

  modport master (
`ifdef COUNTER_UD_GRAY_EN
    input  count_g,
`endif
    output clr, load, load_val, inc, dec, cmp_val,
    input  count, match, wrap, err
  );

  modport slave (
`ifdef COUNTER_UD_GRAY_EN
    output count_g,
`endif
    input  clr, load, load_val, inc, dec, cmp_val,
    output count, match, wrap, err
  );
endinterface

// File: rtl/counter_ud_core.sv
// Next-state and boundary detection for counter_ud; purely combinational.
module counter_ud_core
  import counter_pkg::*;
#(
  parameter int unsigned W   = 12,
  parameter int unsigned SAT = SAT_WRAP
) (
  input  logic [W-1:0] count_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] count_nxt_o,
  output logic         hit_max_o,
  output logic         hit_min_o
);

  op_e          op;
  logic [W-1:0] cnt_max;

  assign cnt_max = '1;

  always_comb begin
    op = OpHold;
    if (clr_i)                op = OpClr;
    else if (load_i)          op = OpLoad;
    else if (inc_i && !dec_i) op = OpUp;
    else if (dec_i && !inc_i) op = OpDown;
  end

  always_comb begin
    count_nxt_o = count_i;
    hit_max_o   = 1'b0;
    hit_min_o   = 1'b0;
    unique case (op)
      OpClr:  count_nxt_o = '0;
      OpLoad: count_nxt_o = load_val_i;
      OpUp: begin
        hit_max_o = (count_i == cnt_max);
        // Saturating mode holds at the boundary; otherwise modulo-2^W wrap.
        if (!(hit_max_o && SAT == SAT_HOLD)) count_nxt_o = count_i + W'(1);
      end
      OpDown: begin
        hit_min_o = (count_i == '0);
        if (!(hit_min_o && SAT == SAT_HOLD)) count_nxt_o = count_i - W'(1);
      end
      default: count_nxt_o = count_i;
    endcase
  end

endmodule

// File: rtl/counter_ud.sv
// Up/down counter with compare match, wrap pulse and sticky error.
// Optional Gray-coded count output enabled by COUNTER_UD_GRAY_EN.
module counter_ud
  import counter_pkg::*;
#(
  parameter int unsigned W   = 12,
  parameter int unsigned SAT = SAT_WRAP
) (
  input logic         clock,
  input logic         reset_n,
  counter_ud_if.slave bus_io
);

  logic [W-1:0] count_d, count_q;
  logic         match_d, match_q;
  logic         wrap_d, wrap_q;
  logic         err_d, err_q;
  logic         hit_max, hit_min;

  counter_ud_core #(
    .W   (W),
    .SAT (SAT)
  ) u_core (
    .count_i     (count_q),
    .clr_i       (bus_io.clr),
    .load_i      (bus_io.load),
    .load_val_i  (bus_io.load_val),
    .inc_i       (bus_io.inc),
    .dec_i       (bus_io.dec),
    .count_nxt_o (count_d),
    .hit_max_o   (hit_max),
    .hit_min_o   (hit_min)
  );

  always_comb begin
    wrap_d  = hit_max | hit_min;
    err_d   = bus_io.clr ? 1'b0 : (err_q | wrap_d);
    // Compare against next-state so match lines up with count.
    match_d = (count_d == bus_io.cmp_val);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
      match_q <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      match_q <= match_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign bus_io.count = count_q;
  assign bus_io.match = match_q;
  assign bus_io.wrap  = wrap_q;
  assign bus_io.err   = err_q;

`ifdef COUNTER_UD_GRAY_EN
  logic [W-1:0] count_g_d, count_g_q;

  assign count_g_d = W'(b2g(32'(count_d)));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_g_q <= '0;
    else          count_g_q <= count_g_d;
  end

  assign bus_io.count_g = count_g_q;
`endif

endmodule

// File: tb/tb_counter_ud.sv
// Scoreboard bench for counter_ud: three instances (W=4 wrap, W=4 saturate, W=32 wrap).
module tb_counter_ud;

  logic        clock;
  logic        reset_n;
  logic [1:0]  sel;
  logic        clr, load, inc, dec;
  logic [31:0] load_val, cmp_val;

  counter_ud_if #(.W(4))  if0 ();
  counter_ud_if #(.W(4))  if1 ();
  counter_ud_if #(.W(32)) if2 ();

  counter_ud #(.W(4),  .SAT(0)) u_dut0 (.clock(clock), .reset_n(reset_n), .bus_io(if0.slave));
  counter_ud #(.W(4),  .SAT(1)) u_dut1 (.clock(clock), .reset_n(reset_n), .bus_io(if1.slave));
  counter_ud #(.W(32), .SAT(0)) u_dut2 (.clock(clock), .reset_n(reset_n), .bus_io(if2.slave));

  // Only the selected instance sees activity; the others idle.
  assign if0.clr = clr & (sel == 2'd0);
  assign if0.load = load & (sel == 2'd0);
  assign if0.inc = inc & (sel == 2'd0);
  assign if0.dec = dec & (sel == 2'd0);
  assign if0.load_val = load_val[3:0];
  assign if0.cmp_val = cmp_val[3:0];
  assign if1.clr = clr & (sel == 2'd1);
  assign if1.load = load & (sel == 2'd1);
  assign if1.inc = inc & (sel == 2'd1);
  assign if1.dec = dec & (sel == 2'd1);
  assign if1.load_val = load_val[3:0];
  assign if1.cmp_val = cmp_val[3:0];
  assign if2.clr = clr & (sel == 2'd2);
  assign if2.load = load & (sel == 2'd2);
  assign if2.inc = inc & (sel == 2'd2);
  assign if2.dec = dec & (sel == 2'd2);
  assign if2.load_val = load_val;
  assign if2.cmp_val = cmp_val;

  logic [31:0] out_count;
  logic        out_wrap, out_err, out_match;

  always_comb begin
    out_count = 32'(if0.count);
    out_wrap  = if0.wrap;
    out_err   = if0.err;
    out_match = if0.match;
    case (sel)
      2'd1: begin
        out_count = 32'(if1.count);
        out_wrap  = if1.wrap;
        out_err   = if1.err;
        out_match = if1.match;
      end
      2'd2: begin
        out_count = if2.count;
        out_wrap  = if2.wrap;
        out_err   = if2.err;
        out_match = if2.match;
      end
      default: ;
    endcase
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    string       name;
    logic [31:0] count;
    logic        wrap;
    logic        err;
    logic        match;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  bit   gray_chk = 0;

  // Drive one cycle of inputs at a negedge and queue the response due after the next posedge.
  task automatic step(input string name, input logic c, input logic l, input logic i,
                      input logic d, input logic [31:0] lv, input logic [31:0] ec,
                      input logic ew, input logic ee, input logic em);
    exp_t e;
    clr = c; load = l; inc = i; dec = d; load_val = lv;
    e.cyc = cyc + 1; e.name = name; e.count = ec; e.wrap = ew; e.err = ee; e.match = em;
    q.push_back(e);
    @(negedge clock);
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Monitor: compare every queued expectation once its cycle's outputs are settled.
  initial begin
`ifdef COUNTER_UD_GRAY_EN
    logic [3:0] prev_g;
    bit         prev_v = 0;
`endif
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (e.cyc != cyc || out_count !== e.count || out_wrap !== e.wrap ||
            out_err !== e.err || out_match !== e.match) begin
          failures++;
          $display("FAIL %s cyc=%0d got count=%0h wrap=%b err=%b match=%b exp count=%0h wrap=%b err=%b match=%b",
                   e.name, cyc, out_count, out_wrap, out_err, out_match,
                   e.count, e.wrap, e.err, e.match);
        end
      end
`ifdef COUNTER_UD_GRAY_EN
      if (gray_chk) begin
        chk("gray_code", 32'(if0.count_g), 32'(if0.count ^ (if0.count >> 1)));
        if (prev_v) chk("gray_step", $countones(if0.count_g ^ prev_g), 32'd1);
        prev_g = if0.count_g;
        prev_v = 1;
      end else begin
        prev_v = 0;
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    reset_n = 1'b0; sel = 2'd0;
    clr = 0; load = 0; inc = 0; dec = 0; load_val = 0; cmp_val = 0;
    #3;
    chk("rst_count", out_count, 0);
    chk("rst_match", 32'(out_match), 0);
    chk("rst_wrap_err", {out_wrap, out_err}, 0);
    @(negedge clock);
    reset_n = 1'b1;
    // First edge after release: match reflects cmp_val==0.
    step("post_rst_match", 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // W=4 wrap: inc x16.
    cmp_val = 15;
    for (int k = 1; k <= 16; k++)
      step("inc_sweep", 0, 0, 1, 0, 0, 32'(k % 16), k == 16, k == 16, (k % 16) == 15);
    step("hold_after_wrap", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    step("dec_at_zero", 0, 0, 0, 1, 0, 15, 1, 1, 1);
    step("clr", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("load5", 0, 1, 0, 0, 5, 5, 0, 0, 0);
    step("clr_beats_load", 1, 1, 1, 0, 9, 0, 0, 0, 0);
    step("load_beats_inc", 0, 1, 1, 0, 9, 9, 0, 0, 0);
    step("clr2", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("dec_wrap", 0, 0, 0, 1, 0, 15, 1, 1, 1);
    step("load_keeps_err", 0, 1, 0, 0, 3, 3, 0, 1, 0);
    step("inc_dec_hold", 0, 0, 1, 1, 0, 3, 0, 1, 0);

    // Gray sweep over 40 incs.
    step("clr3", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    gray_chk = 1;
    for (int k = 1; k <= 40; k++)
      step("gray_sweep", 0, 0, 1, 0, 0, 32'(k % 16), (k % 16) == 0, k >= 16, (k % 16) == 15);
    gray_chk = 0;

    // Reset mid-count with inc held.
    cmp_val = 3;
    step("clr4", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("pre_rst_1", 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step("pre_rst_2", 0, 0, 1, 0, 0, 2, 0, 0, 0);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst_count", out_count, 0);
    chk("midrst_flags", {out_wrap, out_err, out_match}, 0);
    @(posedge clock);
    #1;
    chk("midrst_override", out_count, 0);
    @(negedge clock);
    reset_n = 1'b1;
    step("resume_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("resume_1", 0, 0, 1, 0, 0, 1, 0, 0, 0);
    step("resume_2", 0, 0, 1, 0, 0, 2, 0, 0, 0);
    step("resume_3", 0, 0, 1, 0, 0, 3, 0, 0, 1);
    step("resume_4", 0, 0, 1, 0, 0, 4, 0, 0, 0);
    step("cmp_change", 0, 0, 0, 0, 0, 4, 0, 0, 0);
    cmp_val = 4;
    step("cmp_follow", 0, 0, 0, 0, 0, 4, 0, 0, 1);

    // W=4 saturate.
    clr = 0; load = 0; inc = 0; dec = 0;
    sel = 2'd1; cmp_val = 12;
    step("sat_load14", 0, 1, 0, 0, 14, 14, 0, 0, 0);
    step("sat_inc1", 0, 0, 1, 0, 0, 15, 0, 0, 0);
    step("sat_inc2", 0, 0, 1, 0, 0, 15, 1, 1, 0);
    step("sat_inc3", 0, 0, 1, 0, 0, 15, 1, 1, 0);
    step("sat_dec1", 0, 0, 0, 1, 0, 14, 0, 1, 0);
    step("sat_dec2", 0, 0, 0, 1, 0, 13, 0, 1, 0);
    step("sat_dec3", 0, 0, 0, 1, 0, 12, 0, 1, 1);
    step("sat_clr", 1, 0, 0, 0, 0, 0, 0, 0, 0);
    step("sat_dec_min", 0, 0, 0, 1, 0, 0, 1, 1, 0);

    // W=32 wrap.
    clr = 0; load = 0; inc = 0; dec = 0;
    sel = 2'd2; cmp_val = 0;
    step("w32_load", 0, 1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0);
    step("w32_inc_wrap", 0, 0, 1, 0, 0, 0, 1, 1, 1);
    step("w32_inc_dec", 0, 0, 1, 1, 0, 0, 0, 1, 1);
    step("w32_dec_wrap", 0, 0, 0, 1, 0, 32'hFFFF_FFFF, 1, 1, 0);
    step("w32_idle", 0, 0, 0, 0, 0, 32'hFFFF_FFFF, 0, 1, 0);

    @(posedge clock);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
